// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU sequencer with E-stage stall, annul and zero-divisor handling
// Restoring divider on magnitudes; result_o = {HI remainder, LO quotient}, held until the next DONE.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        ready_o,
  output logic [63:0] result_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ZERO = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic [31:0] a_q, a_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] result_q, result_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff;
  logic [31:0] step_rem, step_quo, fin_quo, fin_rem;

  assign a_mag = (signed_i && a_i[31]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[31]) ? -b_i : b_i;

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, div_q};
  assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
  assign step_quo = {quo_q[30:0], ~diff[32]};
  assign fin_quo  = negq_q ? -step_quo : step_quo;
  assign fin_rem  = negr_q ? -step_rem : step_rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    a_d      = a_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          div_d   = b_mag;
          quo_d   = a_mag;
          rem_d   = 32'h0;
          cnt_d   = 6'd0;
          negq_d  = signed_i & (a_i[31] ^ b_i[31]);
          negr_d  = signed_i & a_i[31];
          state_d = (b_i == 32'h0) ? ZERO : BUSY;
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = {fin_rem, fin_quo};
        end
      end
      ZERO: begin
        state_d  = DONE;
        result_d = {a_q, 32'hFFFF_FFFF};
      end
      default: state_d = IDLE;
    endcase
    // A flush wins over everything, including a result that would land this edge.
    if (annul_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'h0;
      quo_q    <= 32'h0;
      div_q    <= 32'h0;
      a_q      <= 32'h0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      a_q      <= a_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = ~rst & ~annul_i &
                    (((state_q == IDLE) & start_i) | (state_q == BUSY) | (state_q == ZERO));
  assign ready_o  = ~rst & ~annul_i & (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl against an arithmetic reference model
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int checks = 0;
  int failures = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .annul_i(annul_i),
    .stall_o(stall_o), .ready_o(ready_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller is 1ns past a rising edge with the DUT in IDLE (or in DONE's following IDLE for b2b).
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input bit b2b);
    int cycles = 0, stalls = 0;
    bit got = 0, unstable = 0;
    logic [63:0] prev, res;
    start_i = 1'b1; signed_i = s; a_i = a; b_i = b;
    prev = result_o;
    res  = 64'h0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (stall_o) stalls++;
      if (ready_o) begin
        got = 1;
        res = result_o;
        break;
      end
      if (result_o !== prev) unstable = 1;
      @(posedge clk); #1;
      a_i = $urandom; b_i = $urandom; signed_i = $urandom_range(0, 1);
    end
    check("ready_seen", 64'(got), 64'd1);
    check("latency", 64'(cycles), (b == 0) ? 64'd3 : 64'd34);
    check("stall_cycles", 64'(stalls), (b == 0) ? 64'd2 : 64'd33);
    check("result", res, model(s, a, b));
    check("result_stable", 64'(unstable), 64'd0);
    @(posedge clk); #1;
    if (!b2b) start_i = 1'b0;
  endtask

  initial begin
    bit saw_ready;
    bit changed;
    logic [63:0] held;
    logic [31:0] ra, rb;
    bit rs;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = 32'h0; b_i = 32'h0; annul_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; a_i = 32'd9; b_i = 32'd3;
    @(negedge clk);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", result_o, {32'h2, 32'hE});
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_min_m1", result_o, {32'h0, 32'h8000_0000});
    run_div(1'b0, 32'd5, 32'd0, 1'b0);
    check("divu_5_0", result_o, {32'h5, 32'hFFFF_FFFF});
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);

    // Annul at BUSY count 10 (cycle 12 after start).
    held = result_o;
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stall_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    saw_ready = 0; changed = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) saw_ready = 1;
      if (result_o !== held) changed = 1;
      if (stall_o) changed = 1;
      @(posedge clk); #1;
    end
    check("annul_no_ready", 64'(saw_ready), 64'd0);
    check("annul_idle_held", 64'(changed), 64'd0);
    run_div(1'b0, 32'd1000, 32'd3, 1'b0);

    // Back-to-back: start held through DONE, new operands the next cycle.
    run_div(1'b0, 32'hDEAD_BEEF, 32'h1234, 1'b1);
    run_div(1'b1, 32'h8765_4321, 32'hFFFF_FF01, 1'b0);

    // Reset at BUSY count 20 (cycle 22 after start).
    start_i = 1'b1; signed_i = 1'b1; a_i = 32'h7FFF_0000; b_i = 32'd77;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("post_rst_stall", 64'(stall_o), 64'd0);
    check("post_rst_result", result_o, 64'h0);
    saw_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (ready_o) saw_ready = 1;
    end
    check("post_rst_no_ready", 64'(saw_ready), 64'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        default: ;
      endcase
      run_div(rs, ra, rb, n[0]);
    end
    start_i = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have the port start_i, input, 1 bit: a DIV/DIVU is in the E stage; held high while E is stalled.
REQ-004 SHALL have the port signed_i, input, 1 bit: 1 = DIV, 0 = DIVU; sampled with the operands.
REQ-005 SHALL have the port a_i, input, 32 bits: dividend (rs), sampled at start.
REQ-006 SHALL have the port b_i, input, 32 bits: divisor (rt), sampled at start.
REQ-007 SHALL have the port annul_i, input, 1 bit: exception flush; cancels an in-flight divide.
REQ-008 SHALL have the port stall_o, output, 1 bit: the divide-busy stall request to the hazard unit.
REQ-009 SHALL have the port ready_o, output, 1 bit: result_o is valid this cycle.
REQ-010 SHALL have the port result_o, output, 64 bits: {HI = remainder, LO = quotient}.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY, ZERO and DONE.
REQ-012 SHALL latch a_i, b_i and signed_i when start_i=1 in IDLE with annul_i=0.
- Next state is ZERO if b_i==0, otherwise BUSY.
REQ-013 SHALL in BUSY run a 6-bit iteration counter from 0 to 31, one restoring shift-subtract step per cycle on the magnitudes.
- Enter DONE on the cycle after count 31.
REQ-014 SHALL in ZERO spend exactly 1 cycle, then go to DONE.
REQ-015 SHALL in DONE assert ready_o=1 for exactly 1 cycle, then return to IDLE unconditionally.
REQ-016 SHALL drive stall_o = ~annul_i & ((state==IDLE & start_i) | state==BUSY | state==ZERO).
- stall_o is 0 in DONE, so the E stage advances on that edge.
REQ-017 SHALL give 33 stall cycles for a nonzero divisor (IDLE start cycle + 32 BUSY); ready_o rises in the 34th cycle after start_i is first seen.
REQ-018 SHALL give 2 stall cycles for a zero divisor; ready_o rises in the 3rd cycle.
REQ-019 SHALL treat a start_i still high in the DONE cycle as the same instruction, not a new start.
- start_i high in the following IDLE cycle is a new, back-to-back divide.
REQ-020 SHALL compute the signed case as:
- quotient sign = a[31]^b[31]; remainder sign = a[31].
- Operands are converted to magnitude before iterating; results are negated after iterating.
REQ-021 SHALL return quotient 0x80000000 and remainder 0 for -2^31 / -1.
REQ-022 SHALL return LO=0xFFFFFFFF and HI=a for division by zero, signed or unsigned.
REQ-023 SHALL hold result_o stable from DONE until the next DONE; it SHALL NOT change in IDLE, BUSY or ZERO.
REQ-024 SHALL, when annul_i=1 in any cycle:
- Force the next state to IDLE.
- Drive stall_o=0 and ready_o=0 that cycle.
- Leave result_o unchanged.
REQ-025 SHALL give annul_i priority over start_i: a start in the same cycle is ignored.
REQ-026 SHALL ignore a_i, b_i and signed_i changes outside the IDLE start cycle.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set state=IDLE, counter=0, result_o=64'h0 and ready_o=0.
REQ-028 SHALL drive stall_o=0 during reset regardless of start_i.
REQ-029 SHALL abandon an in-flight divide when rst is asserted mid-BUSY; there is no output pulse afterwards.
REQ-030 SHALL, after rst deasserts, accept start_i on the first IDLE cycle.

Verification
REQ-031 SHALL cover DIVU 100/7 -> stall_o high for 33 cycles, ready_o in cycle 34, result_o = {HI 0x2, LO 0xE}.
REQ-032 SHALL cover DIV -7/2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; and DIV 0x80000000/0xFFFFFFFF -> LO 0x80000000, HI 0.
REQ-033 SHALL cover DIVU 5/0 -> 2 stall cycles, then LO 0xFFFFFFFF, HI 0x5.
REQ-034 SHALL cover annul_i pulsed at BUSY count 10:
- stall_o=0 that cycle, then IDLE, no ready_o.
- result_o keeps its prior value.
- A new start then completes correctly.
REQ-035 SHALL cover back-to-back divides (start_i held through DONE, new operands the next cycle) -> two ready_o pulses 34 cycles apart with the correct results.
REQ-036 SHALL cover rst asserted at BUSY count 20 -> next cycle state IDLE, stall_o=0, result_o=0, and no ready_o pulse.
